seven_seg_capture: RTL and testbench
====================================

// Module: seven_seg_capture
// PURPOSE
//  Receiving end of the seven-segment display interface: monitors the multiplexed,
//  active-low segment/anode bus driven to the board display and reconstructs the
//  hex digit, decimal point and validity of every digit position. Used as an
//  on-chip self-check of the up/down counter display path and as a bench scoreboard.
//  Only patterns held stable for STABLE_CYCLES are captured, so scan-switch glitches are rejected.
// PARAMETERS
//  NUM_DIGITS     4   number of anode lines / digit positions (1..8)
//  STABLE_CYCLES  4   consecutive identical samples required before capture (>=2)
// PORTS
//  clk        in   1             system clock; all logic on rising edge
//  rst        in   1             synchronous, active-high reset
//  seg_n      in   8             segments, active-low; [6:0]=g..a, [7]=dp
//  an_n       in   NUM_DIGITS    anodes, active-low; one low = that digit driven
//  err_clr    in   1             clears ghost_err (sync, 1-cycle pulse)
//  digits     out  4*NUM_DIGITS  captured hex values; digit i at [4i+3:4i]
//  dp         out  NUM_DIGITS    1 = decimal point lit on digit i
//  valid      out  NUM_DIGITS    1 = digit i holds a recognised hex glyph
//  blank      out  NUM_DIGITS    1 = digit i last captured all-off (seg_n[6:0]=7'h7F)
//  update     out  1             1-cycle pulse when any digit/dp/valid/blank changes
//  ghost_err  out  1             sticky: >1 anode low while stable
// BEHAVIOUR
//  - Reset: digits=0, dp=0, valid=0, blank=0, update=0, ghost_err=0, counter=0, FSM=IDLE.
//  - Input stage: seg_n/an_n registered once (s_seg, s_an); all decisions use these.
//  - Stability counter: cleared when {s_seg,s_an} differs from previous cycle; else
//    increments, saturating at STABLE_CYCLES-1.
//  - FSM: IDLE  : s_an all-ones -> stay; any low anode -> TRACK.
//         TRACK : counter reaches STABLE_CYCLES-1 -> CAPTURE; s_an all-ones -> IDLE.
//         CAPTURE (1 cycle): evaluate, write, -> HOLD.
//         HOLD  : wait for any change of {s_seg,s_an}, then -> TRACK (or IDLE if all-ones).
//  - CAPTURE, exactly one anode low at index i:
//      dp[i] = ~s_seg[7].
//      s_seg[6:0] matches one of the 16 hex glyphs (0-9,A,b,C,d,E,F per segment_decoder table)
//        -> digits[i]=value, valid[i]=1, blank[i]=0.
//      s_seg[6:0]=7'h7F -> valid[i]=0, blank[i]=1, digits[i] retained.
//      any other pattern -> valid[i]=0, blank[i]=0, digits[i] retained.
//  - CAPTURE, >1 anode low: ghost_err<=1, no digit field written.
//  - update pulses on the cycle after CAPTURE iff any of digits/dp/valid/blank changed;
//    re-capturing identical data gives no pulse.
//  - Latency: input change held steady -> outputs valid STABLE_CYCLES+2 cycles later.
//  - Patterns shorter than STABLE_CYCLES samples are never captured.
//  - err_clr and new ghost condition in same cycle: set wins.
//  - rst mid-TRACK/CAPTURE: all state and outputs return to reset values next edge.
// TESTING (NUM_DIGITS=4, STABLE_CYCLES=4)
//  1. Hold rst 3 cycles with an_n=4'b1110 -> all outputs 0, no update pulse.
//  2. an_n=4'b1110, seg_n=8'b11111001 held 8 cycles -> digits[3:0]=1, valid=4'b0001,
//     one update pulse 6 cycles after first drive; holding longer -> no further pulse.
//  3. an_n=4'b1011, seg_n=8'b10000110 for 3 cycles then 8'b10001110 held -> digits[11:8]=F,
//     never E; exactly one update pulse.
//  4. an_n=4'b1100 held 6 cycles -> ghost_err=1, digits unchanged; err_clr pulse -> 0.
//  5. an_n=4'b0111: seg_n=8'b01000000 -> digits[15:12]=0, dp[3]=1, valid[3]=1;
//     then 8'b11111111 -> blank[3]=1, valid[3]=0, digits[15:12] stays 0.
//  6. Scan 4 digits round-robin (8 cycles each) showing 3,7,A,d; assert rst mid-scan ->
//     outputs 0 next edge; scan resumes -> all four recaptured correctly.

Source files
------------

// File: rtl/seven_seg_capture.sv
// seven_seg_capture
// Monitors a multiplexed, active-low seven-segment bus (segments + anodes) and
// rebuilds, per digit position, the hex value, decimal point, glyph validity
// and blank state. A bus pattern is only captured after it has been sampled
// STABLE_CYCLES times in a row, which filters out scan-switch glitches.
// A capture with more than one anode low is reported as a sticky ghost error.

module seven_seg_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [7:0]              seg_n_i,
    input  logic [NUM_DIGITS-1:0]   an_n_i,
    input  logic                    err_clr_i,
    output logic [4*NUM_DIGITS-1:0] digits_o,
    output logic [NUM_DIGITS-1:0]   dp_o,
    output logic [NUM_DIGITS-1:0]   valid_o,
    output logic [NUM_DIGITS-1:0]   blank_o,
    output logic                    update_o,
    output logic                    ghost_err_o
);

    // Counter only needs to reach STABLE_CYCLES-1, where it saturates.
    localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    // All-segments-off pattern on seg_n[6:0].
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TRACK   = 2'd1,
        S_CAPTURE = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    // Returns {hit, value}; hit=0 when the pattern is not one of the 16 hex glyphs.
    // Segment order is {g,f,e,d,c,b,a}, active-low.
    function automatic logic [4:0] glyph_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h40:   r = {1'b1, 4'h0};
            7'h79:   r = {1'b1, 4'h1};
            7'h24:   r = {1'b1, 4'h2};
            7'h30:   r = {1'b1, 4'h3};
            7'h19:   r = {1'b1, 4'h4};
            7'h12:   r = {1'b1, 4'h5};
            7'h02:   r = {1'b1, 4'h6};
            7'h78:   r = {1'b1, 4'h7};
            7'h00:   r = {1'b1, 4'h8};
            7'h10:   r = {1'b1, 4'h9};
            7'h08:   r = {1'b1, 4'hA};
            7'h03:   r = {1'b1, 4'hB};
            7'h46:   r = {1'b1, 4'hC};
            7'h21:   r = {1'b1, 4'hD};
            7'h06:   r = {1'b1, 4'hE};
            7'h0E:   r = {1'b1, 4'hF};
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // Number of anodes driven (low) in an active-low anode vector.
    function automatic int count_low(input logic [NUM_DIGITS-1:0] an_n);
        int n;
        n = 0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_n[i]) begin
                n = n + 1;
            end
        end
        return n;
    endfunction

    // True when no digit is being driven.
    function automatic logic an_idle(input logic [NUM_DIGITS-1:0] an_n);
        return &an_n;
    endfunction

    // Input sampling stage and one-cycle-delayed copy
    logic [7:0]            s_seg_q;
    logic [NUM_DIGITS-1:0] s_an_q;
    logic [7:0]            p_seg_q;
    logic [NUM_DIGITS-1:0] p_an_q;

    // Stability tracking and FSM
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             same_in;
    state_t           state_q, state_d;

    // Captured display image
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic                    update_q, update_d;
    logic                    ghost_q, ghost_d;

    // Capture evaluation helpers
    int         cap_lows;
    logic [4:0] cap_glyph;

    // Register the bus once and keep the previous sample; reset to an idle bus.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_seg_q <= '1;
            s_an_q  <= '1;
            p_seg_q <= '1;
            p_an_q  <= '1;
        end else begin
            s_seg_q <= seg_n_i;
            s_an_q  <= an_n_i;
            p_seg_q <= s_seg_q;
            p_an_q  <= s_an_q;
        end
    end

    // The incoming sample is compared with the one already held, so the counter
    // is cleared on the same edge that loads a changed pattern into s_seg/s_an.
    // cnt_q == CNT_MAX therefore means the last STABLE_CYCLES samples were equal.
    always_comb begin
        same_in = ({seg_n_i, an_n_i} == {s_seg_q, s_an_q});
        cnt_d   = cnt_q;
        if (!same_in) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Stability counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: track a driven pattern until stable, capture it once,
    // then hold until the bus changes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!an_idle(s_an_q)) begin
                    state_d = S_TRACK;
                end
            end
            S_TRACK: begin
                if (an_idle(s_an_q)) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                // A change always knocks the saturated counter back down, and
                // it cannot climb back to CNT_MAX before HOLD observes it.
                if (cnt_q != CNT_MAX) begin
                    state_d = an_idle(s_an_q) ? S_IDLE : S_TRACK;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs: in CAPTURE, fold the stable pattern (held in p_seg/p_an,
    // which is the last sample counted as stable) into the display image.
    always_comb begin
        digits_d  = digits_q;
        dp_d      = dp_q;
        valid_d   = valid_q;
        blank_d   = blank_q;
        ghost_d   = ghost_q & ~err_clr_i;
        update_d  = 1'b0;
        cap_lows  = count_low(p_an_q);
        cap_glyph = glyph_decode(p_seg_q[6:0]);

        if (state_q == S_CAPTURE) begin
            if (cap_lows > 1) begin
                // Set has priority over a simultaneous err_clr.
                ghost_d = 1'b1;
            end else if (cap_lows == 1) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (!p_an_q[i]) begin
                        dp_d[i] = ~p_seg_q[7];
                        if (cap_glyph[4]) begin
                            digits_d[4*i +: 4] = cap_glyph[3:0];
                            valid_d[i]         = 1'b1;
                            blank_d[i]         = 1'b0;
                        end else if (p_seg_q[6:0] == SEG_BLANK) begin
                            valid_d[i] = 1'b0;
                            blank_d[i] = 1'b1;
                        end else begin
                            valid_d[i] = 1'b0;
                            blank_d[i] = 1'b0;
                        end
                    end
                end
            end
            update_d = ({digits_d, dp_d, valid_d, blank_d} !=
                        {digits_q, dp_q, valid_q, blank_q});
        end
    end

    // Display image, update pulse and sticky ghost flag registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            digits_q <= '0;
            dp_q     <= '0;
            valid_q  <= '0;
            blank_q  <= '0;
            update_q <= 1'b0;
            ghost_q  <= 1'b0;
        end else begin
            digits_q <= digits_d;
            dp_q     <= dp_d;
            valid_q  <= valid_d;
            blank_q  <= blank_d;
            update_q <= update_d;
            ghost_q  <= ghost_d;
        end
    end

    assign digits_o    = digits_q;
    assign dp_o        = dp_q;
    assign valid_o     = valid_q;
    assign blank_o     = blank_q;
    assign update_o    = update_q;
    assign ghost_err_o = ghost_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Testbench for seven_seg_capture (NUM_DIGITS=4, STABLE_CYCLES=4):
// directed vector table, hand-written corner sequences, then randomized
// bus traffic checked against a run-length reference model.

module tb_seven_seg_capture;

    localparam int ND = 4;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    seg_n = 8'hFF;
    logic [ND-1:0] an_n = 4'hF;
    logic          err_clr = 1'b0;
    logic [4*ND-1:0] digits;
    logic [ND-1:0] dp, valid, blank;
    logic          update, ghost;

    seven_seg_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .seg_n_i    (seg_n),
        .an_n_i     (an_n),
        .err_clr_i  (err_clr),
        .digits_o   (digits),
        .dp_o       (dp),
        .valid_o    (valid),
        .blank_o    (blank),
        .update_o   (update),
        .ghost_err_o(ghost)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  an;
        logic [7:0]  seg;
        int          cyc;
        logic [15:0] dig;
        logic [3:0]  dpx;
        logic [3:0]  vld;
        logic [3:0]  blk;
        logic        gh;
        int          upd;
    } vec_t;

    typedef struct packed {
        logic [15:0] dig;
        logic [3:0]  dpx;
        logic [3:0]  vld;
        logic [3:0]  blk;
        logic        upd;
        logic        gh;
    } mst_t;

    int checks = 0;
    int errors = 0;

    vec_t vecs[10];
    logic [6:0] glyph[16];
    logic [7:0] scan_seg[4];
    mst_t mq[$];
    mst_t m, e, old;
    logic [11:0] prevp;
    int run, hold, pulses, first, nlow, idx, g, r, a, b;
    logic [3:0] pan, one;
    logic [7:0] pseg;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] snap();
        return {2'b00, digits, dp, valid, blank, update, ghost};
    endfunction

    // Drive a pattern for n cycles, counting update pulses seen.
    task automatic apply(input logic [3:0] an, input logic [7:0] seg, input int n,
                         output int np, output int fp);
        np = 0;
        fp = 0;
        an_n = an;
        seg_n = seg;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (update === 1'b1) begin
                np++;
                if (fp == 0) fp = k;
            end
        end
    endtask

    task automatic scan_round(output int np);
        int p, f;
        logic [3:0] o;
        np = 0;
        for (int i = 0; i < 4; i++) begin
            o = 4'b0001 << i;
            apply(~o, scan_seg[i], 8, p, f);
            np += p;
        end
    endtask

    initial begin
        glyph[0]  = 7'h40; glyph[1]  = 7'h79; glyph[2]  = 7'h24; glyph[3]  = 7'h30;
        glyph[4]  = 7'h19; glyph[5]  = 7'h12; glyph[6]  = 7'h02; glyph[7]  = 7'h78;
        glyph[8]  = 7'h00; glyph[9]  = 7'h10; glyph[10] = 7'h08; glyph[11] = 7'h03;
        glyph[12] = 7'h46; glyph[13] = 7'h21; glyph[14] = 7'h06; glyph[15] = 7'h0E;
        scan_seg[0] = 8'hB0; scan_seg[1] = 8'hF8; scan_seg[2] = 8'h88; scan_seg[3] = 8'hA1;

        //            an     seg    cyc  dig       dp    vld   blk   gh  upd
        vecs[0] = '{4'hE, 8'hF9, 8, 16'h0001, 4'h0, 4'h1, 4'h0, 1'b0, 1};
        vecs[1] = '{4'hE, 8'hF9, 8, 16'h0001, 4'h0, 4'h1, 4'h0, 1'b0, 0};
        vecs[2] = '{4'hB, 8'h86, 3, 16'h0001, 4'h0, 4'h1, 4'h0, 1'b0, 0};
        vecs[3] = '{4'hB, 8'h8E, 8, 16'h0F01, 4'h0, 4'h5, 4'h0, 1'b0, 1};
        vecs[4] = '{4'hC, 8'hF9, 8, 16'h0F01, 4'h0, 4'h5, 4'h0, 1'b1, 0};
        vecs[5] = '{4'h7, 8'h40, 8, 16'h0F01, 4'h8, 4'hD, 4'h0, 1'b0, 1};
        vecs[6] = '{4'h7, 8'hFF, 8, 16'h0F01, 4'h0, 4'h5, 4'h8, 1'b0, 1};
        vecs[7] = '{4'hF, 8'hFF, 4, 16'h0F01, 4'h0, 4'h5, 4'h8, 1'b0, 0};
        vecs[8] = '{4'hD, 8'hA4, 8, 16'h0F21, 4'h0, 4'h7, 4'h8, 1'b0, 1};
        vecs[9] = '{4'hD, 8'hFE, 8, 16'h0F21, 4'h0, 4'h5, 4'h8, 1'b0, 1};

        // Reset held with a digit driven: everything stays zero.
        rst = 1'b1;
        an_n = 4'hE;
        seg_n = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("reset_state", snap(), 32'h0);
        end
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            apply(vecs[i].an, vecs[i].seg, vecs[i].cyc, pulses, first);
            chk($sformatf("vec%0d_out", i), {11'h0, digits, dp, valid, blank, ghost},
                {11'h0, vecs[i].dig, vecs[i].dpx, vecs[i].vld, vecs[i].blk, vecs[i].gh});
            chk($sformatf("vec%0d_upd", i), pulses, vecs[i].upd);
            if (i == 0) chk("upd_latency", first, 6);
            if (i == 4) begin
                // err_clr pulse clears the sticky flag.
                err_clr = 1'b1;
                @(posedge clk);
                @(negedge clk);
                err_clr = 1'b0;
                chk("ghost_clr", ghost, 1'b0);
                // New ghost capture while err_clr is held: set wins, then clear.
                err_clr = 1'b1;
                an_n = 4'h9;
                seg_n = 8'hFF;
                for (int k = 1; k <= 8; k++) begin
                    @(posedge clk);
                    @(negedge clk);
                    if (k == 5) chk("ghost_pre", ghost, 1'b0);
                    if (k == 6) chk("ghost_set_wins", ghost, 1'b1);
                    if (k == 7) chk("ghost_clr_after", ghost, 1'b0);
                end
                err_clr = 1'b0;
            end
        end

        // Round-robin scan with a reset in the middle.
        scan_round(pulses);
        chk("scan1_out", {digits, valid}, {16'hDA73, 4'hF});
        apply(4'hE, scan_seg[0], 8, pulses, first);
        apply(4'hD, scan_seg[1], 4, pulses, first);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("scan_reset", snap(), 32'h0);
        rst = 1'b0;
        scan_round(pulses);
        scan_round(pulses);
        chk("scan_recap", {12'h0, digits, dp, valid, blank, ghost}, {12'h0, 16'hDA73, 4'h0, 4'hF, 4'h0, 1'b0});
        scan_round(pulses);
        chk("scan_steady_upd", pulses, 0);

        // Randomized traffic against the reference model.
        rst = 1'b1;
        an_n = 4'hF;
        seg_n = 8'hFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m = '0;
        mq.delete();
        repeat (3) mq.push_back(mst_t'(0));
        prevp = {4'hF, 8'hFF};
        run = 100;
        hold = 0;
        one = 4'b0001;
        for (int t = 0; t < 800; t++) begin
            e = mq.pop_front();
            chk("random", snap(), {2'b00, e});
            rst = 1'b0;
            if (hold == 0) begin
                r = $urandom_range(0, 15);
                if (r == 0) begin
                    pan = 4'hF;
                end else if (r == 1) begin
                    a = $urandom_range(0, 3);
                    b = (a + $urandom_range(1, 3)) % 4;
                    pan = 4'hF & ~(one << a) & ~(one << b);
                end else begin
                    pan = ~(one << $urandom_range(0, 3));
                end
                r = $urandom_range(0, 7);
                if (r == 0) pseg = {1'($urandom_range(0, 1)), 7'h7F};
                else if (r == 1) pseg = 8'($urandom);
                else pseg = {1'($urandom_range(0, 1)), glyph[$urandom_range(0, 15)]};
                hold = $urandom_range(1, 7);
            end
            hold--;
            an_n = pan;
            seg_n = pseg;

            // A pattern is captured once, when its 4th identical sample arrives;
            // its effect is visible three cycles later.
            if ({pan, pseg} == prevp) run++;
            else run = 1;
            prevp = {pan, pseg};
            m.upd = 1'b0;
            if (run == SC && pan != 4'hF) begin
                nlow = 0;
                idx = 0;
                for (int i = 0; i < 4; i++) if (!pan[i]) begin nlow++; idx = i; end
                if (nlow > 1) begin
                    m.gh = 1'b1;
                end else begin
                    old = m;
                    m.dpx[idx] = ~pseg[7];
                    g = -1;
                    for (int j = 0; j < 16; j++) if (glyph[j] == pseg[6:0]) g = j;
                    if (g >= 0) begin
                        m.dig[idx*4 +: 4] = 4'(g);
                        m.vld[idx] = 1'b1;
                        m.blk[idx] = 1'b0;
                    end else begin
                        m.vld[idx] = 1'b0;
                        m.blk[idx] = (pseg[6:0] == 7'h7F);
                    end
                    m.upd = ({m.dig, m.dpx, m.vld, m.blk} != {old.dig, old.dpx, old.vld, old.blk});
                end
            end
            mq.push_back(m);
            @(posedge clk);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
